// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path: word width, the NOP
// encoding returned for bad fetches, the fetch FSM states, and a range helper.
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } fetch_state_t;

   // True when a full 32-bit word address falls outside a store of 'depth' words.
   // All 32 bits take part, so high-bit addresses never alias onto low words.
   function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                              input int unsigned        depth);
      logic [WORD_W-1:0] limit;
      limit = WORD_W'(depth);
      return (addr >= limit);
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: DEPTH words of WORD_W bits, synchronous write port and
// asynchronous read port. Contents are not reset, so a reset of the fetch
// logic leaves a loaded program in place.
module instr_mem_array
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // One word written per cycle when the load port is enabled
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read is combinational so the caller decides on which edge the word is sampled;
   // a write on that same edge lands after the sample (read-before-write).
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder side of the instruction-fetch interface. Accepts a word address
// over valid/ready, waits WAIT_STATES cycles, then presents the stored word
// (or NOP plus an error flag for out-of-range addresses) until the consumer
// takes it. A program-load port writes storage in any state.
module instr_fetch_responder
   import mips_pkg::*;
#(
   parameter int unsigned       DEPTH       = 256,
   parameter int unsigned       WAIT_STATES = 2,
   parameter logic [WORD_W-1:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [WORD_W-1:0]        req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WORD_W-1:0]        rsp_data,
   output logic                     rsp_err,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [WORD_W-1:0]        prog_data,
   output logic                     busy
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

   fetch_state_t      state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              busy_q, busy_d;

   logic              req_ready_s;
   logic              accept_s;
   logic              take_s;
   logic              load_s;
   logic [WORD_W-1:0] rd_addr_s;
   logic [AW-1:0]     rd_idx_s;
   logic              rd_oor_s;
   logic [WORD_W-1:0] mem_rdata_s;

   instr_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_idx_s),
      .rdata (mem_rdata_s)
   );

   // Request side is open in IDLE, and in RESP only when the response retires this cycle
   always_comb begin
      req_ready_s = 1'b0;
      case (state_q)
         IDLE:    req_ready_s = 1'b1;
         RESP:    req_ready_s = rsp_ready;
         default: req_ready_s = 1'b0;
      endcase
   end

   assign accept_s = req_valid & req_ready_s;

   // Address used for the storage sample: the held address while waiting,
   // otherwise the live request (zero-wait fetches sample on the accepting edge)
   always_comb begin
      rd_addr_s = req_addr;
      if (state_q == WAIT) begin
         rd_addr_s = addr_q;
      end else begin
         rd_addr_s = req_addr;
      end
      rd_oor_s = addr_out_of_range(rd_addr_s, DEPTH);
      rd_idx_s = rd_addr_s[AW-1:0];
   end

   // Next state, wait counter, captured address and response payload
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      take_s      = 1'b0;
      load_s      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               take_s = 1'b1;
            end else begin
               take_s = 1'b0;
            end
         end
         WAIT: begin
            // cnt of 0 cannot normally occur here; treat it like the last wait cycle
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
               load_s  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready && accept_s) begin
               take_s = 1'b1;
            end else if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               // Backpressure: payload registers simply hold
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b0;
         end
      endcase

      if (take_s) begin
         addr_d = req_addr;
         if (WAIT_STATES == 32'd0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            load_s  = 1'b1;
         end else begin
            state_d     = WAIT;
            cnt_d       = WS_INIT;
            rsp_valid_d = 1'b0;
         end
      end else begin
         addr_d = addr_q;
      end

      if (load_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = rd_oor_s;
         rsp_data_d  = rd_oor_s ? NOP_WORD : mem_rdata_s;
      end else begin
         rsp_err_d = rsp_err_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset drops any request in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_s;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule
